dma_scheduler: RTL and testbench
================================

Name: dma_scheduler

Overview:
- Sequences the four GBA DMA channels: detects start conditions, latches per-channel pending requests, arbitrates by fixed priority (ch0 highest), and negotiates bus ownership with the CPU.
- Grants one channel at a time to the external DMA transfer engine.
- On completion, emits 1-cycle pulses that drive the dma0..dma3 inputs of interrupt_controller.

Parameters:
- NUM_CH, 4, number of channels; fixed at 4 for GBA, widths below use it.
- SWITCH_GAP, 2, idle cycles between releasing one grant and issuing the next (range 0..7).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- ch_enable  in  NUM_CH  DMAxCNT_H bit 15 per channel
- ch_timing  in  2*NUM_CH  start timing per channel: 00 immediate, 01 vblank, 10 hblank, 11 special
- ch_repeat  in  NUM_CH  repeat bit per channel
- ch_irq_en  in  NUM_CH  IRQ-on-end bit per channel
- vblank_pulse  in  1  1-cycle pulse at start of line 160
- hblank_pulse  in  1  1-cycle pulse at hcount 240
- special_trig  in  NUM_CH  sound FIFO (ch1/ch2) / video capture (ch3) request pulses; bit 0 ignored
- bus_ack  in  1  CPU has released the bus
- unit_done  in  1  engine finished one unit (halfword/word) transfer
- xfer_done  in  1  engine finished whole block for the granted channel; coincides with the last unit_done
- bus_req  out  1  request bus from CPU
- grant  out  NUM_CH  one-hot active channel to engine; all-zero when none
- start  out  1  1-cycle pulse: engine loads counters for the granted channel
- clr_enable  out  NUM_CH  1-cycle pulse: clear enable bit in DMAxCNT_H (non-repeat end)
- dma_irq  out  NUM_CH  1-cycle completion pulses to interrupt_controller
- pending  out  NUM_CH  latched request flags (debug/status)

Behaviour:
- Reset values: all outputs 0; pending = 0; state IDLE; enable history register = 0.
- Trigger/set rules, evaluated per channel each cycle while ch_enable = 1:
  - timing 00: set on rising edge of ch_enable, using a registered copy of the previous enable.
  - timing 01: set on vblank_pulse.
  - timing 10: set on hblank_pulse.
  - timing 11: set on special_trig[n]; never for ch0.
- Clear rules:
  - pending[n] clears when xfer_done completes channel n.
  - pending[n] clears when ch_enable[n] = 0. This takes priority over a simultaneous set.
- A trigger arriving while channel n is already pending or active is absorbed; no counting.
- States:
  - IDLE: when any pending, go to REQ next cycle and assert bus_req.
  - REQ: hold bus_req. When bus_ack = 1, latch the highest-priority pending channel into grant and pulse start in the same cycle, then go to RUN.
  - RUN: hold bus_req and grant.
    - On xfer_done: pulse dma_irq[n] if ch_irq_en[n]; pulse clr_enable[n] if ch_repeat[n] = 0 or timing = 00; drop grant; go to GAP.
    - If ch_enable[n] falls mid-RUN: abort at the next unit_done, with no irq and no clr_enable, then go to GAP.
  - GAP: hold bus_req for SWITCH_GAP cycles with grant = 0, then:
    - if any pending, go to REQ; bus_ack is still high, so the grant happens next cycle;
    - else drop bus_req and go to IDLE.
    - With SWITCH_GAP = 0, GAP lasts 1 cycle.
- Latency: immediate enable write to bus_req = 2 cycles (edge detect plus state register). bus_ack to grant/start = 1 cycle.
- bus_ack falling during RUN is a CPU protocol error. The scheduler holds state and grant; the engine stalls.
- Simultaneous xfer_done and a new trigger on the same channel: the completion is processed, then pending is set again. A repeat-mode channel therefore re-runs.
- Reset mid-transfer: everything returns to the reset values immediately. No irq or clr_enable is emitted.

Optional Feature:
- Macro: DMA_PREEMPT_EN.
- Defined: in RUN, on unit_done without xfer_done, if a higher-priority channel is pending, the scheduler drops the current grant and goes to GAP. The current channel stays pending; the engine retains its counters. After the gap, the higher-priority channel is granted with start; the resumed channel later gets start with resume semantics handled by the engine.
- Undefined: the granted channel runs to xfer_done; no preemption.

Test Plan:
- ch3 timing 00, enable 0→1 with bus_ack tied high 1 cycle after bus_req → bus_req at +2 cycles, grant = 4'b1000 and start 1 cycle later. On xfer_done with irq_en = 1 and repeat = 0: dma_irq = 4'b1000 for 1 cycle, clr_enable[3] pulses.
- ch1 and ch2 both timing 01, single vblank_pulse → ch1 granted first. After xfer_done, GAP of 2 cycles with grant = 0, then ch2 granted; bus_req continuous throughout.
- ch1 timing 10, repeat = 1, three hblank_pulses → three separate runs, no clr_enable. A 2nd hblank during an active run is absorbed; no extra run.
- ch0 timing 11 with special_trig[0] pulsed → pending stays 0, bus_req stays 0.
- ch2 active, ch_enable[2] dropped → after next unit_done, grant = 0; no dma_irq, no clr_enable.
- With DMA_PREEMPT_EN: ch3 running, ch0 vblank trigger → at next unit_done ch3 released; ch0 granted after GAP; ch3 regranted after ch0's xfer_done. Without the macro, ch0 waits for ch3's xfer_done.

Source files
------------

// File: rtl/dma_scheduler.sv
// -----------------------------------------------------------------------------
// dma_scheduler
//
// Sequences the four GBA DMA channels. Each channel latches a pending request
// when its start condition fires. Fixed priority picks a channel (ch0 highest).
// The scheduler negotiates the bus with the CPU and then hands one channel at
// a time to the external transfer engine. When a block completes it emits
// one-cycle completion pulses for the interrupt controller and for clearing
// the DMAxCNT_H enable bit.
//
// Optional build macro:
//   DMA_PREEMPT_EN - when defined, a pending higher-priority channel preempts
//                    the running channel at a unit boundary. The preempted
//                    channel stays pending, and the engine resumes it later.
//                    When undefined, a granted channel always runs to xfer_done.
//
// Parameters:
//   NUM_CH      number of channels (4 on the GBA)
//   SWITCH_GAP  idle cycles between dropping one grant and requesting the next
//               (0..7; a value of 0 still spends one cycle in the gap)
//
// Ports:
//   clock, reset    system clock; asynchronous active-high reset
//   ch_enable       per-channel enable (DMAxCNT_H bit 15)
//   ch_timing       2 bits per channel: 00 immediate, 01 vblank, 10 hblank,
//                   11 special
//   ch_repeat       per-channel repeat bit
//   ch_irq_en       per-channel IRQ-on-end bit
//   vblank_pulse    one-cycle pulse at the start of line 160
//   hblank_pulse    one-cycle pulse at hcount 240
//   special_trig    sound FIFO / video capture request pulses (bit 0 unused)
//   bus_ack         CPU has released the bus
//   unit_done       engine finished one unit transfer
//   xfer_done       engine finished the whole block (same cycle as last unit)
//   bus_req         bus request to the CPU
//   grant           one-hot active channel to the engine, zero when idle
//   start           one-cycle pulse: engine loads counters for grant
//   clr_enable      one-cycle pulse: clear the channel's enable bit
//   dma_irq         one-cycle completion pulses to the interrupt controller
//   pending         latched request flags (status)
// -----------------------------------------------------------------------------
module dma_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int SWITCH_GAP = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     ch_enable,
  input  logic [2*NUM_CH-1:0]   ch_timing,
  input  logic [NUM_CH-1:0]     ch_repeat,
  input  logic [NUM_CH-1:0]     ch_irq_en,
  input  logic                  vblank_pulse,
  input  logic                  hblank_pulse,
  input  logic [NUM_CH-1:0]     special_trig,
  input  logic                  bus_ack,
  input  logic                  unit_done,
  input  logic                  xfer_done,
  output logic                  bus_req,
  output logic [NUM_CH-1:0]     grant,
  output logic                  start,
  output logic [NUM_CH-1:0]     clr_enable,
  output logic [NUM_CH-1:0]     dma_irq,
  output logic [NUM_CH-1:0]     pending
);

  // A gap of zero still occupies one cycle in the GAP state.
  localparam int GAP_LEN = (SWITCH_GAP < 1) ? 1 : SWITCH_GAP;
  localparam logic [2:0] GAP_LAST = 3'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RUN,
    ST_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [NUM_CH-1:0]   enable_prev_q, enable_prev_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic                start_q, start_d;
  logic [NUM_CH-1:0]   clr_enable_q, clr_enable_d;
  logic [NUM_CH-1:0]   dma_irq_q, dma_irq_d;
  logic                bus_req_q, bus_req_d;
  logic [2:0]          gap_cnt_q, gap_cnt_d;
  logic                abort_q, abort_d;

  // Per-channel decode.
  logic [NUM_CH-1:0]   trig;       // start condition seen this cycle
  logic [NUM_CH-1:0]   end_clr;    // channel disables itself on completion
  logic [NUM_CH-1:0]   complete;   // block completion of the granted channel
  logic [NUM_CH-1:0]   pick;       // highest-priority pending channel

  // Channel 0 has no special trigger source, so its special_trig bit is unused.
  logic                special_trig0_unused;
  assign special_trig0_unused = special_trig[0];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [1:0] timing;
      assign timing = ch_timing[2*gi +: 2];

      if (gi == 0) begin : g_no_special
        assign trig[gi] = ch_enable[gi] &&
                          (((timing == 2'b00) && !enable_prev_q[gi]) ||
                           ((timing == 2'b01) && vblank_pulse) ||
                           ((timing == 2'b10) && hblank_pulse));
      end else begin : g_special
        assign trig[gi] = ch_enable[gi] &&
                          (((timing == 2'b00) && !enable_prev_q[gi]) ||
                           ((timing == 2'b01) && vblank_pulse) ||
                           ((timing == 2'b10) && hblank_pulse) ||
                           ((timing == 2'b11) && special_trig[gi]));
      end

      // Immediate-mode channels cannot repeat, so they always self-disable.
      assign end_clr[gi] = !ch_repeat[gi] || (timing == 2'b00);

      // A disable wins over everything. A completion clears the flag, but a
      // trigger in the same cycle sets it again so a repeat channel re-runs.
      // A trigger while already pending or active leaves the flag set, so
      // repeated triggers are absorbed rather than counted.
      assign pending_d[gi] = ch_enable[gi] &&
                             ((pending_q[gi] && !complete[gi]) || trig[gi]);
    end
  endgenerate

  // Lowest set bit of pending is the highest-priority channel.
  assign pick = pending_q & (~pending_q + NUM_CH'(1));

  // The granted channel was disabled during this run (or is disabled now).
  // It is abandoned at the next unit boundary.
  logic aborting;
  logic run_abort;
  logic run_complete;

  assign aborting     = abort_q || ((grant_q & ~ch_enable) != '0);
  assign run_abort    = (state_q == ST_RUN) && unit_done && aborting;
  assign run_complete = (state_q == ST_RUN) && xfer_done && !run_abort;
  assign complete     = run_complete ? grant_q : '0;

  assign enable_prev_d = ch_enable;

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    start_d      = 1'b0;
    clr_enable_d = '0;
    dma_irq_d    = '0;
    gap_cnt_d    = gap_cnt_q;
    abort_d      = abort_q;

    case (state_q)
      ST_IDLE: begin
        if (pending_q != '0) begin
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (pending_q == '0) begin
          // Every request was withdrawn before the CPU answered.
          state_d = ST_IDLE;
        end else if (bus_ack) begin
          grant_d = pick;
          start_d = 1'b1;
          abort_d = 1'b0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // bus_ack is deliberately ignored here. If the CPU drops it, that is a
        // protocol error, and the scheduler keeps its grant while the engine
        // stalls.
        abort_d = aborting;
        if (run_abort) begin
          grant_d   = '0;
          gap_cnt_d = '0;
          abort_d   = 1'b0;
          state_d   = ST_GAP;
        end else if (run_complete) begin
          dma_irq_d    = grant_q & ch_irq_en;
          clr_enable_d = grant_q & end_clr;
          grant_d      = '0;
          gap_cnt_d    = '0;
          state_d      = ST_GAP;
        end
`ifdef DMA_PREEMPT_EN
        else if (unit_done && ((pending_q & (grant_q - NUM_CH'(1))) != '0)) begin
          // A higher-priority channel is waiting. Yield at this unit boundary.
          // The current channel keeps its pending flag so it is re-granted.
          grant_d   = '0;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
`endif
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = (pending_q != '0) ? ST_REQ : ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 3'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    bus_req_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      enable_prev_q <= '0;
      grant_q       <= '0;
      start_q       <= 1'b0;
      clr_enable_q  <= '0;
      dma_irq_q     <= '0;
      bus_req_q     <= 1'b0;
      gap_cnt_q     <= '0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      enable_prev_q <= enable_prev_d;
      grant_q       <= grant_d;
      start_q       <= start_d;
      clr_enable_q  <= clr_enable_d;
      dma_irq_q     <= dma_irq_d;
      bus_req_q     <= bus_req_d;
      gap_cnt_q     <= gap_cnt_d;
      abort_q       <= abort_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign grant      = grant_q;
  assign start      = start_q;
  assign clr_enable = clr_enable_q;
  assign dma_irq    = dma_irq_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_dma_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dma_scheduler
//
// Directed bench for dma_scheduler with default parameters (SWITCH_GAP = 2).
// Inputs change 1 ns after each rising edge. Outputs are checked at that same
// point, so every check sees the registered state left by the edge just taken.
// -----------------------------------------------------------------------------
module tb_dma_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ch_enable = '0;
  logic [7:0] ch_timing = '0;
  logic [3:0] ch_repeat = '0;
  logic [3:0] ch_irq_en = '0;
  logic       vblank_pulse = 1'b0;
  logic       hblank_pulse = 1'b0;
  logic [3:0] special_trig = '0;
  logic       bus_ack = 1'b0;
  logic       unit_done = 1'b0;
  logic       xfer_done = 1'b0;
  logic       bus_req;
  logic [3:0] grant;
  logic       start;
  logic [3:0] clr_enable;
  logic [3:0] dma_irq;
  logic [3:0] pending;

  int vectors = 0;
  int errors  = 0;

  dma_scheduler dut (
    .clock        (clock),
    .reset        (reset),
    .ch_enable    (ch_enable),
    .ch_timing    (ch_timing),
    .ch_repeat    (ch_repeat),
    .ch_irq_en    (ch_irq_en),
    .vblank_pulse (vblank_pulse),
    .hblank_pulse (hblank_pulse),
    .special_trig (special_trig),
    .bus_ack      (bus_ack),
    .unit_done    (unit_done),
    .xfer_done    (xfer_done),
    .bus_req      (bus_req),
    .grant        (grant),
    .start        (start),
    .clr_enable   (clr_enable),
    .dma_irq      (dma_irq),
    .pending      (pending)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) begin
      $display("check %s ok (%b)", tag, obs);
    end else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) begin
      $display("check %s ok (%b)", tag, obs);
    end else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One unit transfer, optionally the last one of the block.
  task automatic do_unit(input logic last);
    unit_done = 1'b1;
    xfer_done = last;
    step();
    unit_done = 1'b0;
    xfer_done = 1'b0;
  endtask

  initial begin
    // ---------------- reset state
    step();
    step();
    reset = 1'b0;
    step();
    chk1("rst_bus_req", bus_req, 1'b0);
    chk4("rst_grant", grant, 4'b0000);
    chk1("rst_start", start, 1'b0);
    chk4("rst_pending", pending, 4'b0000);
    chk4("rst_irq", dma_irq, 4'b0000);
    chk4("rst_clr", clr_enable, 4'b0000);

    // ---------------- ch3 immediate, bus_ack one cycle after bus_req
    ch_irq_en = 4'b1000;
    ch_enable = 4'b1000;
    step();
    chk4("t1_pending", pending, 4'b1000);
    chk1("t1_bus_req_early", bus_req, 1'b0);
    step();
    chk1("t1_bus_req_2cyc", bus_req, 1'b1);
    chk4("t1_grant_wait", grant, 4'b0000);
    bus_ack = 1'b1;
    step();
    chk4("t1_grant", grant, 4'b1000);
    chk1("t1_start", start, 1'b1);
    step();
    chk1("t1_start_pulse", start, 1'b0);
    do_unit(1'b0);
    chk4("t1_grant_hold", grant, 4'b1000);
    do_unit(1'b1);
    chk4("t1_irq", dma_irq, 4'b1000);
    chk4("t1_clr", clr_enable, 4'b1000);
    chk4("t1_grant_drop", grant, 4'b0000);
    chk4("t1_pending_clr", pending, 4'b0000);
    ch_enable = 4'b0000;
    step();
    chk4("t1_irq_pulse", dma_irq, 4'b0000);
    chk4("t1_clr_pulse", clr_enable, 4'b0000);
    chk1("t1_gap_bus_req", bus_req, 1'b1);
    step();
    chk1("t1_idle_bus_req", bus_req, 1'b0);

    // ---------------- ch1 + ch2 on one vblank: priority and gap
    ch_timing = 8'b00_01_01_00;
    ch_irq_en = 4'b0110;
    ch_enable = 4'b0110;
    step();
    chk4("t2_no_trig", pending, 4'b0000);
    vblank_pulse = 1'b1;
    step();
    vblank_pulse = 1'b0;
    chk4("t2_pending", pending, 4'b0110);
    step();
    chk1("t2_bus_req", bus_req, 1'b1);
    step();
    chk4("t2_grant_ch1", grant, 4'b0010);
    chk1("t2_start_ch1", start, 1'b1);
    do_unit(1'b1);
    chk4("t2_irq_ch1", dma_irq, 4'b0010);
    chk4("t2_pending_ch2", pending, 4'b0100);
    chk4("t2_gap0_grant", grant, 4'b0000);
    ch_enable = 4'b0100;
    step();
    chk4("t2_gap1_grant", grant, 4'b0000);
    chk1("t2_gap1_bus_req", bus_req, 1'b1);
    step();
    chk4("t2_req_grant", grant, 4'b0000);
    chk1("t2_req_bus_req", bus_req, 1'b1);
    step();
    chk4("t2_grant_ch2", grant, 4'b0100);
    chk1("t2_start_ch2", start, 1'b1);
    do_unit(1'b1);
    chk4("t2_irq_ch2", dma_irq, 4'b0100);
    chk4("t2_clr_ch2", clr_enable, 4'b0100);
    ch_enable = 4'b0000;
    step();
    step();
    chk1("t2_idle", bus_req, 1'b0);

    // ---------------- ch1 hblank repeat: three runs, absorbed retrigger
    ch_timing = 8'b00_00_10_00;
    ch_irq_en = 4'b0000;
    ch_repeat = 4'b0010;
    ch_enable = 4'b0010;
    step();
    for (int r = 0; r < 3; r++) begin
      hblank_pulse = 1'b1;
      step();
      hblank_pulse = 1'b0;
      chk4($sformatf("t3_pending_r%0d", r), pending, 4'b0010);
      step();
      step();
      chk4($sformatf("t3_grant_r%0d", r), grant, 4'b0010);
      chk1($sformatf("t3_start_r%0d", r), start, 1'b1);
      if (r == 0) begin
        hblank_pulse = 1'b1;
        step();
        hblank_pulse = 1'b0;
        chk4("t3_absorb_pending", pending, 4'b0010);
      end
      do_unit(1'b0);
      do_unit(1'b1);
      chk4($sformatf("t3_clr_r%0d", r), clr_enable, 4'b0000);
      chk4($sformatf("t3_irq_r%0d", r), dma_irq, 4'b0000);
      chk4($sformatf("t3_done_pending_r%0d", r), pending, 4'b0000);
      step();
      step();
      chk1($sformatf("t3_idle_r%0d", r), bus_req, 1'b0);
    end

    // completion coinciding with a new trigger re-arms the channel
    hblank_pulse = 1'b1;
    step();
    hblank_pulse = 1'b0;
    step();
    step();
    chk4("t3b_grant", grant, 4'b0010);
    hblank_pulse = 1'b1;
    do_unit(1'b1);
    hblank_pulse = 1'b0;
    chk4("t3b_rearm_pending", pending, 4'b0010);
    chk4("t3b_grant_drop", grant, 4'b0000);
    step();
    step();
    step();
    chk4("t3b_regrant", grant, 4'b0010);
    chk1("t3b_restart", start, 1'b1);
    do_unit(1'b1);
    chk4("t3b_pending_clr", pending, 4'b0000);
    ch_enable = 4'b0000;
    ch_repeat = 4'b0000;
    step();
    step();
    chk1("t3b_idle", bus_req, 1'b0);

    // ---------------- ch0 special timing never triggers
    ch_timing = 8'b00_00_00_11;
    ch_enable = 4'b0001;
    special_trig = 4'b0001;
    step();
    special_trig = 4'b0000;
    chk4("t4_pending", pending, 4'b0000);
    step();
    step();
    chk1("t4_bus_req", bus_req, 1'b0);
    ch_enable = 4'b0000;

    // ---------------- ch2 disabled mid-run: abort at next unit
    ch_timing = 8'b00_00_00_00;
    ch_irq_en = 4'b0100;
    ch_enable = 4'b0100;
    step();
    chk4("t5_pending", pending, 4'b0100);
    step();
    step();
    chk4("t5_grant", grant, 4'b0100);
    do_unit(1'b0);
    ch_enable = 4'b0000;
    step();
    chk4("t5_grant_hold", grant, 4'b0100);
    chk4("t5_pending_clr", pending, 4'b0000);
    do_unit(1'b0);
    chk4("t5_grant_drop", grant, 4'b0000);
    chk4("t5_no_irq", dma_irq, 4'b0000);
    chk4("t5_no_clr", clr_enable, 4'b0000);
    step();
    step();
    chk1("t5_idle", bus_req, 1'b0);

    // ---------------- ch3 running, ch0 vblank arrives
    ch_timing = 8'b00_00_00_01;
    ch_irq_en = 4'b1001;
    ch_enable = 4'b1001;
    step();
    chk4("t6_pending", pending, 4'b1000);
    step();
    step();
    chk4("t6_grant_ch3", grant, 4'b1000);
    vblank_pulse = 1'b1;
    step();
    vblank_pulse = 1'b0;
    chk4("t6_pending_both", pending, 4'b1001);
    do_unit(1'b0);
`ifdef DMA_PREEMPT_EN
    chk4("t6_preempt_drop", grant, 4'b0000);
    chk4("t6_preempt_pending", pending, 4'b1001);
    chk4("t6_preempt_no_irq", dma_irq, 4'b0000);
    step();
    step();
    step();
    chk4("t6_grant_ch0", grant, 4'b0001);
    chk1("t6_start_ch0", start, 1'b1);
    do_unit(1'b1);
    chk4("t6_irq_ch0", dma_irq, 4'b0001);
    chk4("t6_pending_ch3", pending, 4'b1000);
    ch_enable = 4'b1000;
    step();
    step();
    step();
    chk4("t6_regrant_ch3", grant, 4'b1000);
    chk1("t6_restart_ch3", start, 1'b1);
    do_unit(1'b1);
    chk4("t6_irq_ch3", dma_irq, 4'b1000);
`else
    chk4("t6_no_preempt", grant, 4'b1000);
    do_unit(1'b1);
    chk4("t6_irq_ch3", dma_irq, 4'b1000);
    chk4("t6_pending_ch0", pending, 4'b0001);
    ch_enable = 4'b0001;
    step();
    step();
    step();
    chk4("t6_grant_ch0", grant, 4'b0001);
    chk1("t6_start_ch0", start, 1'b1);
    do_unit(1'b1);
    chk4("t6_irq_ch0", dma_irq, 4'b0001);
`endif
    ch_enable = 4'b0000;
    step();
    step();
    chk1("t6_idle", bus_req, 1'b0);

    // ---------------- reset during a transfer
    ch_timing = 8'b00_00_00_00;
    ch_irq_en = 4'b0010;
    ch_enable = 4'b0010;
    step();
    step();
    step();
    chk4("t7_grant", grant, 4'b0010);
    reset = 1'b1;
    #1;
    chk4("t7_rst_grant", grant, 4'b0000);
    chk1("t7_rst_bus_req", bus_req, 1'b0);
    chk4("t7_rst_pending", pending, 4'b0000);
    do_unit(1'b1);
    chk4("t7_rst_no_irq", dma_irq, 4'b0000);
    chk4("t7_rst_no_clr", clr_enable, 4'b0000);
    ch_enable = 4'b0000;
    step();
    reset = 1'b0;
    step();
    step();
    chk1("t7_after_bus_req", bus_req, 1'b0);
    chk4("t7_after_pending", pending, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
